dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between the CPU MEM stage and a DMA/loader port, and grants round-robin on contention. Each access is stretched over a parameterised number of wait-state cycles, with read data registered per port. It sits between the pipeline's MEM stage and the data memory, and drives the CPU stall while a CPU access is outstanding.

---
 rtl/dmem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory between the CPU MEM stage and a DMA/loader
// port. One transfer is in flight at a time. On contention the port that was
// not granted last wins. Each transfer holds the memory for LAT cycles, then
// a one-cycle DONE state pulses the granted port's ack.
//
// Parameters
//   LAT          memory access cycles per transfer, legal range 1..15
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   cpu_req_i    CPU request, held until cpu_ack_o
//   cpu_we_i     CPU write enable (1 = write, 0 = read)
//   cpu_addr_i   CPU byte address
//   cpu_wdata_i  CPU write data
//   cpu_rdata_o  last completed CPU read data (registered)
//   cpu_ack_o    one-cycle CPU completion pulse
//   cpu_stall_o  CPU stall, cpu_req_i & ~cpu_ack_o
//   dma_*        same meaning as cpu_* for the DMA port (no stall output)
//   mem_addr_o   word-aligned memory address, valid during ACCESS
//   mem_write_o  memory write enable, ACCESS only
//   mem_read_o   memory read enable, ACCESS only
//   mem_wdata_o  memory write data, valid during ACCESS
//   mem_rdata_i  combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_stall_o,

    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic [31:0] dma_rdata_o,
    output logic        dma_ack_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // The counter runs LAT-1 down to 0, so ACCESS lasts exactly LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    // Low address bits are dropped when the request is latched, so the
    // stored address is already word-aligned.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_dma_q, last_dma_d;  // 1: DMA was granted last
    logic        gnt_dma_q, gnt_dma_d;    // 1: current transfer belongs to DMA
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    // DMA wins when it is the only requester, or on a tie when the CPU was
    // granted last. Reset sets last_dma_q so the CPU takes the first tie.
    logic pick_dma;
    assign pick_dma = dma_req_i & (~cpu_req_i | ~last_dma_q);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dma_d  = last_dma_q;
        gnt_dma_d   = gnt_dma_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        cpu_ack_o   = 1'b0;
        dma_ack_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    gnt_dma_d = pick_dma;
                    if (pick_dma) begin
                        we_d    = dma_we_i;
                        addr_d  = dma_addr_i & WORD_MASK;
                        wdata_d = dma_wdata_i;
                    end else begin
                        we_d    = cpu_we_i;
                        addr_d  = cpu_addr_i & WORD_MASK;
                        wdata_d = cpu_wdata_i;
                    end
                    cnt_d   = CNT_INIT;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // Port inputs are not looked at here; only latched values
                // reach the memory.
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_write_o = we_q;
                mem_read_o  = ~we_q;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = S_DONE;
                    last_dma_d = gnt_dma_q;
                    // Read data is captured on the final access cycle so it
                    // is already on rdata_o when ack rises.
                    if (!we_q) begin
                        if (gnt_dma_q) begin
                            dma_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end

            S_DONE: begin
                cpu_ack_o = ~gnt_dma_q;
                dma_ack_o = gnt_dma_q;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The stall must rise in the same cycle as the request, so it stays
    // combinational rather than registered.
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // An in-flight transfer is abandoned: no ack, rdata untouched
            // beyond its reset value.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_dma_q  <= 1'b1;
            gnt_dma_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dma_q  <= last_dma_d;
            gnt_dma_q   <= gnt_dma_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. Three instances share clock and reset:
//   u_lat2 (LAT=2) with a small writable memory model,
//   u_lat4 (LAT=4) and u_lat1 (LAT=1) with a fixed address-derived read
//   pattern (rdata = addr ^ 32'h5A5A_0000).
// Inputs change 1 ns after the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // ---------------- LAT=2 instance ----------------
    logic        a_cpu_req, a_cpu_we, a_dma_req, a_dma_we;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
    logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_cpu_ack, a_cpu_stall, a_dma_ack, a_mem_write, a_mem_read;

    dmem_arbiter #(.LAT(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(a_cpu_req), .cpu_we_i(a_cpu_we), .cpu_addr_i(a_cpu_addr),
        .cpu_wdata_i(a_cpu_wdata), .cpu_rdata_o(a_cpu_rdata), .cpu_ack_o(a_cpu_ack),
        .cpu_stall_o(a_cpu_stall),
        .dma_req_i(a_dma_req), .dma_we_i(a_dma_we), .dma_addr_i(a_dma_addr),
        .dma_wdata_i(a_dma_wdata), .dma_rdata_o(a_dma_rdata), .dma_ack_o(a_dma_ack),
        .mem_addr_o(a_mem_addr), .mem_write_o(a_mem_write), .mem_read_o(a_mem_read),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
    );

    // Memory model: preloaded words plus a written-word overlay.
    logic [255:0] wvalid;
    logic [31:0]  wmem [256];

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0000_0010: rom = 32'hDEAD_BEEF;
            32'h0000_0020: rom = 32'hC0C0_0001;
            32'h0000_0030: rom = 32'hD0D0_0002;
            32'h0000_0100: rom = 32'h1111_2222;
            default:       rom = 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvalid <= '0;
        end else if (a_mem_write) begin
            wvalid[a_mem_addr[9:2]] <= 1'b1;
            wmem[a_mem_addr[9:2]]   <= a_mem_wdata;
        end
    end

    assign a_mem_rdata = wvalid[a_mem_addr[9:2]] ? wmem[a_mem_addr[9:2]] : rom(a_mem_addr);

    // ---------------- LAT=4 instance ----------------
    logic        b_cpu_req;
    logic [31:0] b_cpu_addr;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_mem_write, b_mem_read;

    dmem_arbiter #(.LAT(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(b_cpu_req), .cpu_we_i(1'b0), .cpu_addr_i(b_cpu_addr),
        .cpu_wdata_i(32'h0), .cpu_rdata_o(b_cpu_rdata), .cpu_ack_o(b_cpu_ack),
        .cpu_stall_o(b_cpu_stall),
        .dma_req_i(1'b0), .dma_we_i(1'b0), .dma_addr_i(32'h0),
        .dma_wdata_i(32'h0), .dma_rdata_o(b_dma_rdata), .dma_ack_o(b_dma_ack),
        .mem_addr_o(b_mem_addr), .mem_write_o(b_mem_write), .mem_read_o(b_mem_read),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
    );
    assign b_mem_rdata = b_mem_addr ^ 32'h5A5A_0000;

    // ---------------- LAT=1 instance ----------------
    logic        c_cpu_req;
    logic [31:0] c_cpu_addr;
    logic [31:0] c_cpu_rdata, c_dma_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
    logic        c_cpu_ack, c_cpu_stall, c_dma_ack, c_mem_write, c_mem_read;

    dmem_arbiter #(.LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(c_cpu_req), .cpu_we_i(1'b0), .cpu_addr_i(c_cpu_addr),
        .cpu_wdata_i(32'h0), .cpu_rdata_o(c_cpu_rdata), .cpu_ack_o(c_cpu_ack),
        .cpu_stall_o(c_cpu_stall),
        .dma_req_i(1'b0), .dma_we_i(1'b0), .dma_addr_i(32'h0),
        .dma_wdata_i(32'h0), .dma_rdata_o(c_dma_rdata), .dma_ack_o(c_dma_ack),
        .mem_addr_o(c_mem_addr), .mem_write_o(c_mem_write), .mem_read_o(c_mem_read),
        .mem_wdata_o(c_mem_wdata), .mem_rdata_i(c_mem_rdata)
    );
    assign c_mem_rdata = c_mem_addr ^ 32'h5A5A_0000;

    // One cycle: falling edge, then 1 ns of settling.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h100; a_cpu_wdata = 32'h0;
        a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 32'h200; a_dma_wdata = 32'h0;
        repeat (2) step();
        checks++; if ({a_mem_read, a_mem_write} !== 2'b00) begin errors++;
            $display("FAIL rst_mem_en got %b expected 00", {a_mem_read, a_mem_write}); end
        checks++; if (a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin errors++;
            $display("FAIL rst_mem_bus got addr %h wdata %h expected 0", a_mem_addr, a_mem_wdata); end
        checks++; if ({a_cpu_ack, a_dma_ack} !== 2'b00) begin errors++;
            $display("FAIL rst_acks got %b expected 00", {a_cpu_ack, a_dma_ack}); end
        checks++; if (a_cpu_rdata !== 32'h0 || a_dma_rdata !== 32'h0) begin errors++;
            $display("FAIL rst_rdata got cpu %h dma %h expected 0", a_cpu_rdata, a_dma_rdata); end
        checks++; if (a_cpu_stall !== 1'b1) begin errors++;
            $display("FAIL rst_stall got %b expected 1", a_cpu_stall); end

        rst_n = 1'b1;
        step();  // first ACCESS cycle: CPU must win the tie
        checks++; if (a_mem_read !== 1'b1 || a_mem_addr !== 32'h100) begin errors++;
            $display("FAIL rst_first_grant got read %b addr %h expected 1 00000100", a_mem_read, a_mem_addr); end
        step();
        step();  // DONE
        checks++; if ({a_cpu_ack, a_dma_ack} !== 2'b10) begin errors++;
            $display("FAIL rst_first_ack got %b expected 10", {a_cpu_ack, a_dma_ack}); end
        checks++; if (a_cpu_rdata !== 32'h1111_2222) begin errors++;
            $display("FAIL rst_first_rdata got %h expected 11112222", a_cpu_rdata); end
        a_cpu_req = 1'b0; a_dma_req = 1'b0;
        repeat (2) step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_cpu_read();
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h12;
        #1;
        checks++; if (a_cpu_stall !== 1'b1) begin errors++;
            $display("FAIL rd_stall_rise got %b expected 1", a_cpu_stall); end
        for (int n = 1; n <= 4; n++) begin
            logic        e_rd, e_ack, e_stall;
            logic [31:0] e_addr;
            step();
            e_rd    = (n <= 2);
            e_ack   = (n == 3);
            e_stall = (n < 3);
            e_addr  = e_rd ? 32'h10 : 32'h0;
            checks++; if (a_mem_read !== e_rd || a_mem_addr !== e_addr) begin errors++;
                $display("FAIL rd_mem n=%0d got read %b addr %h expected %b %h", n, a_mem_read, a_mem_addr, e_rd, e_addr); end
            checks++; if (a_cpu_ack !== e_ack || a_cpu_stall !== e_stall) begin errors++;
                $display("FAIL rd_ack_stall n=%0d got ack %b stall %b expected %b %b", n, a_cpu_ack, a_cpu_stall, e_ack, e_stall); end
            if (n >= 3) begin
                checks++; if (a_cpu_rdata !== 32'hDEAD_BEEF) begin errors++;
                    $display("FAIL rd_rdata n=%0d got %h expected deadbeef", n, a_cpu_rdata); end
            end
            if (n == 3) a_cpu_req = 1'b0;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_write_readback();
        int wcount;
        wcount = 0;
        a_dma_req = 1'b1; a_dma_we = 1'b1; a_dma_addr = 32'h40; a_dma_wdata = 32'h0000_00A5;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (a_mem_write === 1'b1) begin
                wcount++;
                checks++; if (a_mem_addr !== 32'h40 || a_mem_wdata !== 32'hA5 || a_mem_read !== 1'b0) begin errors++;
                    $display("FAIL wr_bus n=%0d got addr %h wdata %h read %b expected 40 a5 0", n, a_mem_addr, a_mem_wdata, a_mem_read); end
            end
            checks++; if (a_dma_ack !== (n == 3) || a_cpu_ack !== 1'b0) begin errors++;
                $display("FAIL wr_ack n=%0d got dma %b cpu %b expected %b 0", n, a_dma_ack, a_cpu_ack, (n == 3)); end
            if (n == 3) a_dma_req = 1'b0;
        end
        checks++; if (wcount != 2) begin errors++;
            $display("FAIL wr_cycles got %0d expected 2", wcount); end
        checks++; if (a_dma_rdata !== 32'h0 || a_cpu_rdata !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL wr_rdata_hold got dma %h cpu %h expected 0 deadbeef", a_dma_rdata, a_cpu_rdata); end

        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h40;
        for (int n = 1; n <= 4; n++) begin
            step();
            checks++; if (a_cpu_ack !== (n == 3)) begin errors++;
                $display("FAIL rb_ack n=%0d got %b expected %b", n, a_cpu_ack, (n == 3)); end
            if (n == 3) begin
                checks++; if (a_cpu_rdata !== 32'hA5) begin errors++;
                    $display("FAIL rb_rdata got %h expected a5", a_cpu_rdata); end
                a_cpu_req = 1'b0;
            end
        end
        checks++; if (a_dma_rdata !== 32'h0) begin errors++;
            $display("FAIL rb_dma_hold got %h expected 0", a_dma_rdata); end
    endtask

    // -------------------------------------------------------------------------
    // Last grant is CPU here, so the tie goes DMA, CPU, DMA, CPU.
    task automatic test_contention();
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h20;
        a_dma_req = 1'b1; a_dma_we = 1'b0; a_dma_addr = 32'h30;
        for (int n = 1; n <= 16; n++) begin
            logic        e_cack, e_dack;
            logic [31:0] e_addr;
            step();
            e_dack = (n == 3) || (n == 11);
            e_cack = (n == 7) || (n == 15);
            if (n == 1 || n == 2 || n == 9 || n == 10)       e_addr = 32'h30;
            else if (n == 5 || n == 6 || n == 13 || n == 14) e_addr = 32'h20;
            else                                             e_addr = 32'h0;
            checks++; if (a_cpu_ack !== e_cack || a_dma_ack !== e_dack) begin errors++;
                $display("FAIL rr_ack n=%0d got cpu %b dma %b expected %b %b", n, a_cpu_ack, a_dma_ack, e_cack, e_dack); end
            checks++; if (a_mem_addr !== e_addr) begin errors++;
                $display("FAIL rr_addr n=%0d got %h expected %h", n, a_mem_addr, e_addr); end
            if (n == 15) begin a_cpu_req = 1'b0; a_dma_req = 1'b0; end
        end
        checks++; if (a_cpu_rdata !== 32'hC0C0_0001 || a_dma_rdata !== 32'hD0D0_0002) begin errors++;
            $display("FAIL rr_rdata got cpu %h dma %h expected c0c00001 d0d00002", a_cpu_rdata, a_dma_rdata); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_access();
        b_cpu_addr = 32'h8; b_cpu_req = 1'b1;
        step();
        checks++; if (b_mem_read !== 1'b1 || b_mem_addr !== 32'h8) begin errors++;
            $display("FAIL rm_access1 got read %b addr %h expected 1 8", b_mem_read, b_mem_addr); end
        step();  // second ACCESS cycle
        checks++; if (b_mem_read !== 1'b1) begin errors++;
            $display("FAIL rm_access2 got read %b expected 1", b_mem_read); end
        rst_n = 1'b0; b_cpu_req = 1'b0;
        #1;
        checks++; if (b_mem_read !== 1'b0 || b_mem_addr !== 32'h0) begin errors++;
            $display("FAIL rm_async got read %b addr %h expected 0 0", b_mem_read, b_mem_addr); end
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++; if (b_cpu_ack !== 1'b0 || b_mem_read !== 1'b0 || b_cpu_rdata !== 32'h0) begin errors++;
                $display("FAIL rm_quiet n=%0d got ack %b read %b rdata %h expected 0 0 0", n, b_cpu_ack, b_mem_read, b_cpu_rdata); end
        end
        b_cpu_addr = 32'hC; b_cpu_req = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++; if (b_mem_read !== (n <= 4) || b_cpu_ack !== (n == 5)) begin errors++;
                $display("FAIL rm_fresh n=%0d got read %b ack %b expected %b %b", n, b_mem_read, b_cpu_ack, (n <= 4), (n == 5)); end
            if (n == 5) begin
                checks++; if (b_cpu_rdata !== 32'h5A5A_000C) begin errors++;
                    $display("FAIL rm_fresh_rdata got %h expected 5a5a000c", b_cpu_rdata); end
                b_cpu_req = 1'b0;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back_lat1();
        c_cpu_addr = 32'h4; c_cpu_req = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            logic        e_rd, e_ack, e_stall;
            logic [31:0] e_addr;
            step();
            e_rd    = (n == 1) || (n == 4) || (n == 7);
            e_ack   = (n == 2) || (n == 5) || (n == 8);
            e_stall = (n <= 8) && !e_ack;
            e_addr  = (n == 1) ? 32'h4 : (n == 4) ? 32'h8 : (n == 7) ? 32'hC : 32'h0;
            checks++; if (c_mem_read !== e_rd || c_mem_addr !== e_addr) begin errors++;
                $display("FAIL l1_mem n=%0d got read %b addr %h expected %b %h", n, c_mem_read, c_mem_addr, e_rd, e_addr); end
            checks++; if (c_cpu_ack !== e_ack || c_cpu_stall !== e_stall) begin errors++;
                $display("FAIL l1_ack_stall n=%0d got ack %b stall %b expected %b %b", n, c_cpu_ack, c_cpu_stall, e_ack, e_stall); end
            if (e_ack) begin
                logic [31:0] e_data;
                e_data = (n == 2) ? 32'h5A5A_0004 : (n == 5) ? 32'h5A5A_0008 : 32'h5A5A_000C;
                checks++; if (c_cpu_rdata !== e_data) begin errors++;
                    $display("FAIL l1_rdata n=%0d got %h expected %h", n, c_cpu_rdata, e_data); end
            end
            if (n == 2) c_cpu_addr = 32'h8;
            if (n == 5) c_cpu_addr = 32'hC;
            if (n == 8) c_cpu_req = 1'b0;
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        b_cpu_req = 1'b0; b_cpu_addr = 32'h0;
        c_cpu_req = 1'b0; c_cpu_addr = 32'h0;
        test_reset();
        test_cpu_read();
        test_write_readback();
        test_contention();
        test_reset_mid_access();
        test_back_to_back_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
